// File: rtl/aes_dec_pkg.sv
// ---------------------------------------------------------------------------
// aes_dec_pkg
// Shared definitions for the AES decryption datapath.
//   NR_DEFAULT  : default number of rounds (AES-128)
//   ROUND_W     : width of the round index / key-schedule index
//   XTIME_POLY  : reduction constant for multiply-by-x in GF(2^8) mod 0x11B
//   xtime()     : multiply a byte by x (02) in GF(2^8)
//   gf_mul()    : multiply a byte by one of the InvMixColumns constants
//                 09 / 0b / 0d / 0e; any other constant yields 0
// ---------------------------------------------------------------------------
package aes_dec_pkg;

    localparam int unsigned NR_DEFAULT = 10;
    localparam int unsigned ROUND_W    = 4;
    localparam logic [7:0]  XTIME_POLY = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? XTIME_POLY : 8'h00);
    endfunction

    // Constants are built from a*8, a*4, a*2 and a, all reached by xtime chains.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] r;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            8'h09:   r = x8 ^ a;
            8'h0B:   r = x8 ^ x2 ^ a;
            8'h0D:   r = x8 ^ x4 ^ a;
            8'h0E:   r = x8 ^ x4 ^ x2;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// ---------------------------------------------------------------------------
// inv_mix_column
// Combinational InvMixColumns on one 32-bit column. Row 0 is the MSB byte.
//   col_i [31:0] : input column  {a0, a1, a2, a3}
//   col_o [31:0] : output column {b0, b1, b2, b3}
// ---------------------------------------------------------------------------
module inv_mix_column
    import aes_dec_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0_s;
    logic [7:0] a1_s;
    logic [7:0] a2_s;
    logic [7:0] a3_s;

    assign a0_s = col_i[31:24];
    assign a1_s = col_i[23:16];
    assign a2_s = col_i[15:8];
    assign a3_s = col_i[7:0];

    assign col_o[31:24] = gf_mul(a0_s, 8'h0E) ^ gf_mul(a1_s, 8'h0B) ^ gf_mul(a2_s, 8'h0D) ^ gf_mul(a3_s, 8'h09);
    assign col_o[23:16] = gf_mul(a0_s, 8'h09) ^ gf_mul(a1_s, 8'h0E) ^ gf_mul(a2_s, 8'h0B) ^ gf_mul(a3_s, 8'h0D);
    assign col_o[15:8]  = gf_mul(a0_s, 8'h0D) ^ gf_mul(a1_s, 8'h09) ^ gf_mul(a2_s, 8'h0E) ^ gf_mul(a3_s, 8'h0B);
    assign col_o[7:0]   = gf_mul(a0_s, 8'h0B) ^ gf_mul(a1_s, 8'h0D) ^ gf_mul(a2_s, 8'h09) ^ gf_mul(a3_s, 8'h0E);

endmodule

// File: rtl/aes_inv_addkey_mixcol.sv
// ---------------------------------------------------------------------------
// aes_inv_addkey_mixcol
// Back half of an AES decryption round: AddRoundKey then InvMixColumns
// (skipped on the final round), with a registered result. Owns the round
// counter that indexes the key schedule.
//
// Build option: define AES_INV_MIX_PIPE_EN to add a register between the key
// XOR and InvMixColumns (latency 2 instead of 1).
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   iStart     : first round of a new block (qualified by iValid)
//   iValid     : iBlockIn / iRoundKey valid
//   iBlockIn   : 128-bit state, column-major, row 0 in the MSB byte
//   iRoundKey  : round key for oKeyIdx, same byte order
//   oKeyIdx    : combinational key-schedule index for this cycle
//   oBlockOut  : registered result state
//   oValid     : one-cycle pulse per accepted input
//   oLast      : result is the final-round output (plaintext)
//   oBusy      : a block is in flight
// ---------------------------------------------------------------------------
module aes_inv_addkey_mixcol
    import aes_dec_pkg::*;
#(
    parameter int unsigned NR = NR_DEFAULT
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iStart,
    input  logic                iValid,
    input  logic [127:0]        iBlockIn,
    input  logic [127:0]        iRoundKey,
    output logic [ROUND_W-1:0]  oKeyIdx,
    output logic [127:0]        oBlockOut,
    output logic                oValid,
    output logic                oLast,
    output logic                oBusy
);

    localparam logic [ROUND_W-1:0] FIRST_IDX = ROUND_W'(NR - 1);

    logic [ROUND_W-1:0] round_q, round_d;
    logic               active_q, active_d;
    logic [127:0]       block_q, block_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;

    logic               start_s;
    logic               accept_s;
    logic [ROUND_W-1:0] idx_s;
    logic               final_s;
    logic [127:0]       tmp_s;
    logic [127:0]       mix_in_s;
    logic [127:0]       mix_out_s;

    // A start is accepted in any state and restarts the count; continuation
    // rounds are accepted only while a block is active.
    assign start_s  = iValid & iStart;
    assign accept_s = start_s | (iValid & active_q);
    assign idx_s    = start_s ? FIRST_IDX : round_q;
    assign final_s  = (idx_s == {ROUND_W{1'b0}});
    assign tmp_s    = iBlockIn ^ iRoundKey;
    assign oKeyIdx  = idx_s;

    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_mix_column u_col (
            .col_i (mix_in_s[127-32*c -: 32]),
            .col_o (mix_out_s[127-32*c -: 32])
        );
    end

    // Round counter next-state: count down per accept, park at 0 after the last round.
    always_comb begin
        round_d  = round_q;
        active_d = active_q;
        if (accept_s) begin
            if (final_s) begin
                round_d  = {ROUND_W{1'b0}};
                active_d = 1'b0;
            end else begin
                round_d  = idx_s - {{(ROUND_W-1){1'b0}}, 1'b1};
                active_d = 1'b1;
            end
        end else begin
            round_d  = round_q;
            active_d = active_q;
        end
    end

    // Round counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_q  <= {ROUND_W{1'b0}};
            active_q <= 1'b0;
        end else begin
            round_q  <= round_d;
            active_q <= active_d;
        end
    end

`ifdef AES_INV_MIX_PIPE_EN
    logic [127:0] s1_data_q, s1_data_d;
    logic         s1_valid_q, s1_valid_d;
    logic         s1_last_q, s1_last_d;

    assign mix_in_s = s1_data_q;

    // Stage 1 captures the keyed state plus the bypass decision; stage 2 mixes or bypasses.
    always_comb begin
        s1_valid_d = accept_s;
        s1_last_d  = accept_s & final_s;
        s1_data_d  = s1_data_q;
        block_d    = block_q;
        if (accept_s) begin
            s1_data_d = tmp_s;
        end else begin
            s1_data_d = s1_data_q;
        end
        if (s1_valid_q) begin
            block_d = s1_last_q ? s1_data_q : mix_out_s;
        end else begin
            block_d = block_q;
        end
        valid_d = s1_valid_q;
        last_d  = s1_valid_q & s1_last_q;
    end

    // Intermediate pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q  <= 128'd0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
        end
    end

    // Busy covers the round still travelling through stage 1.
    assign oBusy = active_q | s1_valid_q;
`else
    assign mix_in_s = tmp_s;

    // Result mux: final round bypasses InvMixColumns; hold the last result when idle.
    always_comb begin
        block_d = block_q;
        if (accept_s) begin
            block_d = final_s ? tmp_s : mix_out_s;
        end else begin
            block_d = block_q;
        end
        valid_d = accept_s;
        last_d  = accept_s & final_s;
    end

    assign oBusy = active_q;
`endif

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block_q <= 128'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            block_q <= block_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign oBlockOut = block_q;
    assign oValid    = valid_q;
    assign oLast     = last_q;

endmodule

// File: doc/aes_inv_addkey_mixcol.md
# aes_inv_addkey_mixcol

Decryption round back-half for the AES datapath. It takes the registered 128-bit state from the inverse SubBytes/ShiftRows stage, XORs in the round key, applies InvMixColumns on every round except the final one, and registers the result for the next round or for output. It owns the decryption round counter, which drives the key-schedule index and flags the last round and the completed block.

## Interface
- NR, default 10: number of rounds (AES-128). Counter width is 4 bits; legal NR range is 2..15.
- clk  in  1  : single clock, rising edge.
- rst_n  in  1  : asynchronous, active-low reset.
- iStart  in  1  : first round of a new block. Sampled only when iValid=1.
- iValid  in  1  : iBlockIn and iRoundKey are valid this cycle.
- iBlockIn  in  128  : state from the upstream stage. Column-major: column c = bits [127-32c -: 32]; row 0 is the MSB byte.
- iRoundKey  in  128  : round key for index oKeyIdx. Same byte order as iBlockIn.
- oKeyIdx  out  4  : combinational key-schedule index for the round now accepted.
- oBlockOut  out  128  : result state.
- oValid  out  1  : oBlockOut valid, one-cycle pulse per accepted input.
- oLast  out  1  : qualifies oValid; result is the final-round output (plaintext).
- oBusy  out  1  : a block is in flight (counter active).

## Operation
- Round counter rRound is 4 bits, reset value 0. Flag rActive, reset value 0.
- When iValid=1 and iStart=1, the cycle uses round index NR-1, and rActive is set. This applies regardless of the current state: a new start aborts any block in flight.
- When iValid=1, iStart=0 and rActive=1, the cycle uses rRound.
- oKeyIdx = (iValid & iStart) ? NR-1 : rRound. It is combinational, and the key source must return iRoundKey in the same cycle.
- For each accepted cycle with index r:
  - tmp = iBlockIn ^ iRoundKey.
  - If r ≠ 0, tmp passes through InvMixColumns. Per column, with multiplication in GF(2^8) mod 0x11B:
    - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
    - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
    - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
    - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
  - If r = 0, InvMixColumns is bypassed and oLast is asserted with the result.
  - After accept, rRound = r-1. When r = 0, rActive clears and rRound returns to 0.
- iValid=1 with iStart=0 and rActive=0 is ignored: no output, no counter change.
- oBusy = rActive.
- No backpressure. The downstream stage must accept oValid every cycle it is asserted.

## Timing
- Reset values: oBlockOut=0, oValid=0, oLast=0, oBusy=0, rRound=0. oKeyIdx=0 unless iValid&iStart.
- Latency is 1 cycle from an accepted iValid to oValid (default build). See Configuration.
- Throughput is one round per cycle. Back-to-back iValid is legal; iValid gaps stall the counter.
- iStart on the same cycle as the r=0 accept: the start wins, the old block's final output is dropped, and the new block begins at NR-1.
- Reset asserted mid-block clears everything asynchronously. Outputs already in the pipeline are discarded.

## Configuration
- AES_INV_MIX_PIPE_EN defined:
  - An extra register stage is inserted between the key XOR and InvMixColumns.
  - Latency is 2 cycles. oValid and oLast are delayed together with the data; the r=0 bypass decision travels with the data.
  - oBusy stays asserted until the final output has been presented.
- Undefined: XOR and InvMixColumns are in one combinational path, and latency is 1.

## Structure
- Shared package aes_dec_pkg:
  - NR default and the round index width.
  - The xtime constant 8'h1B.
  - Function gf_mul(byte, const) covering constants 09/0b/0d/0e.
- Sub-module inv_mix_column: combinational, 32-bit in / 32-bit out, instantiated 4 times (one per column).

## Test plan
- Reset: hold rst_n=0, then release → all outputs 0, oBusy=0, oKeyIdx=0.
- Single round, InvMixColumns check: iStart=1, iValid=1, iBlockIn = column 8e4da1bc ×4, key=0 → oKeyIdx=9 during the accept, after latency oBlockOut = db135345 ×4, oLast=0.
- Further InvMixColumns vectors with key=0: column 9fdc589d → f20a225c; column 01010101 → 01010101; column c6c6c6c6 → c6c6c6c6.
- Key XOR and final round: drive 10 consecutive accepts with keys 0, block for the last round = 00112233…ff and key 000102…0f → oKeyIdx steps 9..0; final output = 00102030405060708090a0b0c0d0e0f0 with oLast=1; oBusy falls after it.
- Gaps and ignore: insert 3 idle cycles mid-block → the counter holds; iValid with iStart=0 while idle → no oValid.
- Abort and reset: iStart during round 4 → oKeyIdx=9 and the count restarts. Assert rst_n low mid-block → no further oValid, and the counter is 0.
